ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem_pkg.sv | 67 ++++++
 rtl/ex_mem.sv | 103 ++++++++++
 tb/tb_ex_mem.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared widths, reset level, NOP encodings and payload type for the EX/MEM pipeline register.
package ex_mem_pkg;

    // Bus widths
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_W      = 32;
    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned DREG_W     = 64;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned CNT_W      = 2;

    // Stall vector bit positions
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;

    // Reset is active-low: the level that means "in reset"
    localparam logic RST_ENABLE = 1'b0;

    // Write-enable levels
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Idle encodings
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = REG_ADDR_W'(0);
    localparam logic [REG_W-1:0]      ZERO_WORD    = REG_W'(0);
    localparam logic [DREG_W-1:0]     ZERO_DWORD   = DREG_W'(0);
    localparam logic [CNT_W-1:0]      ZERO_CNT     = CNT_W'(0);
    localparam logic [ALU_OP_W-1:0]   ALU_OP_NOP   = ALU_OP_W'(8'b0000_0000);
    localparam logic [ALU_OP_W-1:0]   ALU_OP_LW    = ALU_OP_W'(8'b1110_0011);

    // Everything that travels from EX into the MEM stage
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_W-1:0]      wdata;
        logic [REG_W-1:0]      hi;
        logic [REG_W-1:0]      lo;
        logic                  whilo;
        logic [ALU_OP_W-1:0]   aluop;
        logic [REG_W-1:0]      mem_addr;
        logic [REG_W-1:0]      reg2;
    } mem_payload_t;

    // Bubble inserted into MEM: no register write, no HI/LO write, NOP opcode
    localparam mem_payload_t MEM_PAYLOAD_NOP = '{
        wd:       NOP_REG_ADDR,
        wreg:     WRITE_DISABLE,
        wdata:    ZERO_WORD,
        hi:       ZERO_WORD,
        lo:       ZERO_WORD,
        whilo:    WRITE_DISABLE,
        aluop:    ALU_OP_NOP,
        mem_addr: ZERO_WORD,
        reg2:     ZERO_WORD
    };

    // EX stalled while MEM keeps moving: MEM must receive a bubble
    function automatic logic is_bubble(input logic [STALL_W-1:0] stall);
        return stall[STALL_EX] && !stall[STALL_MEM];
    endfunction

    // EX and MEM both stalled: the register holds its contents
    function automatic logic is_hold(input logic [STALL_W-1:0] stall);
        return stall[STALL_EX] && stall[STALL_MEM];
    endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall bubbles/holds, exception flush and madd/msub state loop-back.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,

    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [REG_W-1:0]      ex_wdata,
    input  logic [REG_W-1:0]      ex_hi,
    input  logic [REG_W-1:0]      ex_lo,
    input  logic                  ex_whilo,
    input  logic [ALU_OP_W-1:0]   ex_aluop,
    input  logic [REG_W-1:0]      ex_mem_addr,
    input  logic [REG_W-1:0]      ex_reg2,
    input  logic [DREG_W-1:0]     hilo_i,
    input  logic [CNT_W-1:0]      cnt_i,

    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [REG_W-1:0]      mem_wdata,
    output logic [REG_W-1:0]      mem_hi,
    output logic [REG_W-1:0]      mem_lo,
    output logic                  mem_whilo,
    output logic [ALU_OP_W-1:0]   mem_aluop,
    output logic [REG_W-1:0]      mem_mem_addr,
    output logic [REG_W-1:0]      mem_reg2,
    output logic [DREG_W-1:0]     hilo_o,
    output logic [CNT_W-1:0]      cnt_o
);

    mem_payload_t      ex_payload;
    mem_payload_t      mem_q;
    logic [DREG_W-1:0] hilo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bubble;
    logic              hold;
    logic              unused_stall;

    // Stall decode; only the EX and MEM bits matter to this stage
    assign bubble       = is_bubble(stall);
    assign hold         = is_hold(stall);
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Gather the EX-side fields into one payload
    assign ex_payload = '{
        wd:       ex_wd,
        wreg:     ex_wreg,
        wdata:    ex_wdata,
        hi:       ex_hi,
        lo:       ex_lo,
        whilo:    ex_whilo,
        aluop:    ex_aluop,
        mem_addr: ex_mem_addr,
        reg2:     ex_reg2
    };

    // MEM-bound payload: reset > flush > bubble > hold > pass
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            mem_q <= MEM_PAYLOAD_NOP;
        end else if (flush) begin
            mem_q <= MEM_PAYLOAD_NOP;
        end else if (bubble) begin
            mem_q <= MEM_PAYLOAD_NOP;
        end else if (!hold) begin
            mem_q <= ex_payload;
        end
    end

    // madd/msub partial state: captured while EX is stalled, cleared once EX moves on
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hilo_q <= ZERO_DWORD;
            cnt_q  <= ZERO_CNT;
        end else if (flush) begin
            hilo_q <= ZERO_DWORD;
            cnt_q  <= ZERO_CNT;
        end else if (bubble) begin
            hilo_q <= hilo_i;
            cnt_q  <= cnt_i;
        end else if (!hold) begin
            hilo_q <= ZERO_DWORD;
            cnt_q  <= ZERO_CNT;
        end
    end

    assign mem_wd       = mem_q.wd;
    assign mem_wreg     = mem_q.wreg;
    assign mem_wdata    = mem_q.wdata;
    assign mem_hi       = mem_q.hi;
    assign mem_lo       = mem_q.lo;
    assign mem_whilo    = mem_q.whilo;
    assign mem_aluop    = mem_q.aluop;
    assign mem_mem_addr = mem_q.mem_addr;
    assign mem_reg2     = mem_q.reg2;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: driver queues hand-computed expectations, negedge monitor checks them.
module tb_ex_mem;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } out_t;

    out_t  exp_q[$];
    string name_q[$];
    int    total;
    int    bad;
    logic  done;

    ex_mem dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_hi        (ex_hi),
        .ex_lo        (ex_lo),
        .ex_whilo     (ex_whilo),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .hilo_i       (hilo_i),
        .cnt_i        (cnt_i),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .mem_whilo    (mem_whilo),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .hilo_o       (hilo_o),
        .cnt_o        (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one output snapshot per cycle, checked against the oldest expectation
    always @(negedge clk) begin
        out_t  act;
        out_t  e;
        string n;
        act = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata, hi: mem_hi, lo: mem_lo,
                whilo: mem_whilo, aluop: mem_aluop, mem_addr: mem_mem_addr, reg2: mem_reg2,
                hilo: hilo_o, cnt: cnt_o};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total = total + 1;
            if (act !== e) begin
                bad = bad + 1;
                $display("FAIL %s: got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b aluop=%h addr=%h reg2=%h hilo=%h cnt=%h",
                         n, act.wd, act.wreg, act.wdata, act.hi, act.lo, act.whilo, act.aluop,
                         act.mem_addr, act.reg2, act.hilo, act.cnt);
                $display("     %s: want wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b aluop=%h addr=%h reg2=%h hilo=%h cnt=%h",
                         n, e.wd, e.wreg, e.wdata, e.hi, e.lo, e.whilo, e.aluop,
                         e.mem_addr, e.reg2, e.hilo, e.cnt);
            end
        end else if (done) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // Neutral input state: out of reset, no stall, no flush, all data zero
    task automatic idle_inputs();
        rst = 1'b1; stall = 6'b0; flush = 1'b0;
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
        ex_whilo = 1'b0; ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
        hilo_i = '0; cnt_i = '0;
    endtask

    // Queue the expectation for the coming edge, then advance to just after the next negedge
    task automatic step(input string n, input out_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        out_t e;
        total = 0;
        bad   = 0;
        done  = 1'b0;

        // Reset with every input driven high
        idle_inputs();
        rst = 1'b0; stall = 6'h3F; flush = 1'b1;
        ex_wd = '1; ex_wreg = 1'b1; ex_wdata = '1; ex_hi = '1; ex_lo = '1; ex_whilo = 1'b1;
        ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1; hilo_i = '1; cnt_i = '1;
        step("reset_all_ones", '0);
        stall = 6'h00; flush = 1'b0;
        step("reset_no_stall", '0);

        // Plain pass; pass also clears hilo_o/cnt_o
        idle_inputs();
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        hilo_i = 64'h1111_2222_3333_4444; cnt_i = 2'd3;
        e = '0; e.wd = 5'd3; e.wreg = 1'b1; e.wdata = 32'h1234_5678;
        step("pass_basic", e);
        total = total + 1;
        if (mem_wd !== 5'd3 || mem_wdata !== 32'h1234_5678 || cnt_o !== 2'd0) begin
            bad = bad + 1;
            $display("FAIL direct_pass: got wd=%h wdata=%h cnt=%h want wd=03 wdata=12345678 cnt=0",
                     mem_wd, mem_wdata, cnt_o);
        end

        // Bubble: MEM gets zeros, madd state tracks the inputs
        idle_inputs();
        stall = 6'b001000; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
        hilo_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd1;
        e = '0; e.hilo = 64'hDEAD_BEEF_0000_0001; e.cnt = 2'd1;
        for (int k = 0; k < 4; k++) step("bubble_track", e);
        total = total + 1;
        if (hilo_o !== 64'hDEAD_BEEF_0000_0001 || cnt_o !== 2'd1 || mem_wreg !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL direct_bubble: got hilo=%h cnt=%h wreg=%b want hilo=deadbeef00000001 cnt=1 wreg=0",
                     hilo_o, cnt_o, mem_wreg);
        end
        hilo_i = 64'hDEAD_BEEF_0000_0002; cnt_i = 2'd2;
        e.hilo = 64'hDEAD_BEEF_0000_0002; e.cnt = 2'd2;
        step("bubble_track_new", e);
        stall = 6'b101111;
        hilo_i = 64'h0000_0000_FFFF_0003; cnt_i = 2'd3;
        e.hilo = 64'h0000_0000_FFFF_0003; e.cnt = 2'd3;
        step("bubble_ignored_bits", e);

        // Load a value, then hold it for four edges while EX changes
        idle_inputs();
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hA5A5_A5A5;
        e = '0; e.wd = 5'd5; e.wreg = 1'b1; e.wdata = 32'hA5A5_A5A5;
        step("pass_load", e);
        idle_inputs();
        stall = 6'b011000; hilo_i = 64'h5555_5555_5555_5555; cnt_i = 2'd3;
        for (int k = 0; k < 4; k++) step("hold_keep", e);
        total = total + 1;
        if (mem_wdata !== 32'hA5A5_A5A5) begin
            bad = bad + 1;
            $display("FAIL direct_hold: got wdata=%h want a5a5a5a5", mem_wdata);
        end
        stall = 6'b111111;
        step("hold_ignored_bits", e);

        // MEM-only stall counts as pass
        idle_inputs();
        stall = 6'b010000; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_F00D;
        hilo_i = 64'h0F0F_0F0F_0F0F_0F0F; cnt_i = 2'd2;
        e = '0; e.wd = 5'd9; e.wreg = 1'b1; e.wdata = 32'hCAFE_F00D;
        step("mem_only_stall_pass", e);

        // Build madd state, then flush under a full hold
        idle_inputs();
        stall = 6'b001000; hilo_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'd1;
        e = '0; e.hilo = 64'h0123_4567_89AB_CDEF; e.cnt = 2'd1;
        step("bubble_setup", e);
        idle_inputs();
        stall = 6'b011000; flush = 1'b1; ex_wd = 5'd12; ex_wreg = 1'b1; ex_wdata = 32'h7777_7777;
        ex_whilo = 1'b1; ex_hi = 32'h9; ex_aluop = 8'hE3; hilo_i = 64'h1; cnt_i = 2'd1;
        step("flush_over_hold", '0);
        total = total + 1;
        if (hilo_o !== 64'h0 || cnt_o !== 2'd0 || mem_wd !== 5'd0 || mem_whilo !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL direct_flush: got hilo=%h cnt=%h wd=%h whilo=%b want all zero",
                     hilo_o, cnt_o, mem_wd, mem_whilo);
        end

        // Full pass of HI/LO and load fields
        idle_inputs();
        ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF; ex_whilo = 1'b1;
        ex_hi = 32'h0000_0001; ex_lo = 32'h0000_0002; ex_aluop = 8'hE3;
        ex_mem_addr = 32'h8000_0010; ex_reg2 = 32'h0BAD_C0DE;
        e = '0; e.wd = 5'd31; e.wreg = 1'b1; e.wdata = 32'hFFFF_FFFF; e.whilo = 1'b1;
        e.hi = 32'h0000_0001; e.lo = 32'h0000_0002; e.aluop = 8'hE3;
        e.mem_addr = 32'h8000_0010; e.reg2 = 32'h0BAD_C0DE;
        step("pass_hilo_lw", e);
        total = total + 1;
        if (mem_mem_addr !== 32'h8000_0010 || mem_aluop !== 8'hE3 || mem_lo !== 32'h0000_0002) begin
            bad = bad + 1;
            $display("FAIL direct_lw: got addr=%h aluop=%h lo=%h want addr=80000010 aluop=e3 lo=00000002",
                     mem_mem_addr, mem_aluop, mem_lo);
        end

        // Bubble then hold, then reset in the middle of the hold
        idle_inputs();
        stall = 6'b001000; hilo_i = 64'hAAAA_AAAA_AAAA_AAAA; cnt_i = 2'd2;
        e = '0; e.hilo = 64'hAAAA_AAAA_AAAA_AAAA; e.cnt = 2'd2;
        step("bubble_before_hold", e);
        stall = 6'b011000; hilo_i = 64'h0; cnt_i = 2'd0;
        step("hold_madd_state", e);
        rst = 1'b0;
        step("reset_mid_hold", '0);

        // Flush in pass and in bubble modes
        idle_inputs();
        stall = 6'b001000; hilo_i = 64'h0000_0000_0000_00FF; cnt_i = 2'd1;
        e = '0; e.hilo = 64'h0000_0000_0000_00FF; e.cnt = 2'd1;
        step("bubble_before_flush", e);
        flush = 1'b1; hilo_i = 64'h1234; cnt_i = 2'd2;
        step("flush_over_bubble", '0);
        idle_inputs();
        flush = 1'b1; ex_wd = 5'd4; ex_wreg = 1'b1; ex_wdata = 32'h4444_4444;
        step("flush_over_pass", '0);
        idle_inputs();
        ex_wd = 5'd1; ex_wreg = 1'b1; ex_wdata = 32'h0000_0042;
        e = '0; e.wd = 5'd1; e.wreg = 1'b1; e.wdata = 32'h0000_0042;
        step("pass_after_flush", e);

        done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL drain: monitor did not finish, pending=%0d want=0", exp_q.size());
        $fatal(1, "scoreboard did not drain");
    end

endmodule
